// File: rtl/fpu_flag_accum_if.sv
// Issue/completion/commit/CSR bundle between the FPU pipelines and the flag accumulator.
// The slave side is the accumulator; the master side drives allocations, completions and commits.
interface fpu_flag_accum_if #(
    parameter int NCH  = 3,
    parameter int TAGW = 2
);
    logic                  AllocValid;
    logic                  AllocReady;
    logic [TAGW-1:0]       AllocTag;
    logic [NCH-1:0]        DoneValid;
    logic [NCH*TAGW-1:0]   DoneTag;
    logic [NCH*5-1:0]      DoneFlg;
    logic                  CommitReady;
    logic                  Commit;
    logic                  Flush;
    logic                  CSRWe;
    logic [4:0]            CSRWdata;
    logic [4:0]            FFlags;
    logic                  FlagEvent;
    logic [TAGW:0]         Count;

    modport master (
        output AllocValid, DoneValid, DoneTag, DoneFlg, Commit, Flush, CSRWe, CSRWdata,
        input  AllocReady, AllocTag, CommitReady, FFlags, FlagEvent, Count
    );

    modport slave (
        input  AllocValid, DoneValid, DoneTag, DoneFlg, Commit, Flush, CSRWe, CSRWdata,
        output AllocReady, AllocTag, CommitReady, FFlags, FlagEvent, Count
    );
endinterface

// File: rtl/fpu_flag_accum.sv
// In-order FP exception-flag accumulator: out-of-order completions, in-order retire into sticky fflags (1-cycle update).
// Backpressure: AllocReady drops when all DEPTH entries are pending; commits only take a valid, done head.
module fpu_flag_accum #(
    parameter int NCH   = 3,
    parameter int DEPTH = 4,
    parameter int TAGW  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    fpu_flag_accum_if.slave   bus
);

    localparam logic [TAGW:0] PTR_ONE = {{TAGW{1'b0}}, 1'b1};

    logic [TAGW:0]          head_q, head_d;
    logic [TAGW:0]          tail_q, tail_d;
    logic [DEPTH-1:0]       valid_q, valid_d;
    logic [DEPTH-1:0]       done_q, done_d;
    logic [DEPTH-1:0][4:0]  flg_q, flg_d;
    logic [4:0]             fflags_q, fflags_d;
    logic                   flag_event_q, flag_event_d;

    logic [TAGW-1:0]        head_idx;
    logic [TAGW-1:0]        tail_idx;
    logic [TAGW-1:0]        done_tag;
    logic                   full;
    logic                   commit_ready;
    logic                   retire;
    logic                   do_alloc;
    logic [4:0]             cf;

    assign head_idx     = head_q[TAGW-1:0];
    assign tail_idx     = tail_q[TAGW-1:0];
    assign full         = (head_q[TAGW] != tail_q[TAGW]) && (head_idx == tail_idx);
    assign commit_ready = valid_q[head_idx] & done_q[head_idx];
    assign retire       = bus.Commit & commit_ready;
    assign do_alloc     = bus.AllocValid & ~full & ~bus.Flush;
    assign cf           = flg_q[head_idx];

    always_comb begin
        valid_d  = valid_q;
        done_d   = done_q;
        flg_d    = flg_q;
        head_d   = head_q;
        tail_d   = tail_q;
        done_tag = '0;

        // Several channels may hit the same tag; accumulating into flg_d ORs them all.
        for (int i = 0; i < NCH; i++) begin
            done_tag = bus.DoneTag[i*TAGW +: TAGW];
            if (!bus.Flush && bus.DoneValid[i] && valid_q[done_tag]) begin
                done_d[done_tag] = 1'b1;
                flg_d[done_tag]  = flg_d[done_tag] | bus.DoneFlg[i*5 +: 5];
            end
        end

        if (do_alloc) begin
            valid_d[tail_idx] = 1'b1;
            done_d[tail_idx]  = 1'b0;
            flg_d[tail_idx]   = 5'b00000;
            tail_d            = tail_q + PTR_ONE;
        end

        if (retire) begin
            valid_d[head_idx] = 1'b0;
            head_d            = head_q + PTR_ONE;
        end

        // Flush keeps the same-cycle retirement, then collapses the tail onto the new head.
        if (bus.Flush) begin
            valid_d = '0;
            done_d  = '0;
            tail_d  = head_d;
        end
    end

    always_comb begin
        fflags_d     = fflags_q;
        flag_event_d = retire & ~bus.CSRWe & (|(cf & ~fflags_q));
        if (bus.CSRWe) begin
            fflags_d = bus.CSRWdata;
        end else if (retire) begin
            fflags_d = fflags_q | cf;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q       <= '0;
            tail_q       <= '0;
            valid_q      <= '0;
            done_q       <= '0;
            flg_q        <= '0;
            fflags_q     <= 5'b00000;
            flag_event_q <= 1'b0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            valid_q      <= valid_d;
            done_q       <= done_d;
            flg_q        <= flg_d;
            fflags_q     <= fflags_d;
            flag_event_q <= flag_event_d;
        end
    end

    assign bus.AllocReady  = ~full;
    assign bus.AllocTag    = tail_idx;
    assign bus.CommitReady = commit_ready;
    assign bus.Count       = tail_q - head_q;
    assign bus.FFlags      = fflags_q;
    assign bus.FlagEvent   = flag_event_q;

endmodule
